// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every non-clock/reset signal of the shared-ALU arbiter.
//   Requester 0/1 : rN_valid, rN_ready, rN_op[3:0], rN_x, rN_y
//   Response      : rsp_valid, rsp_ready, rsp_id, rsp_err, rsp_data[2*BITS]
//   ALU side      : alu_ctrl[SIG_COUNT], alu_x, alu_y, alu_result[2*BITS]
// Modports:
//   slave  - the arbiter itself
//   master - requesters, response consumer and ALU taken together
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int BITS      = 32,
  parameter int SIG_COUNT = 12
);
  logic                 r0_valid;
  logic                 r0_ready;
  logic [3:0]           r0_op;
  logic [BITS-1:0]      r0_x;
  logic [BITS-1:0]      r0_y;

  logic                 r1_valid;
  logic                 r1_ready;
  logic [3:0]           r1_op;
  logic [BITS-1:0]      r1_x;
  logic [BITS-1:0]      r1_y;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic                 rsp_err;
  logic [2*BITS-1:0]    rsp_data;

  logic [SIG_COUNT-1:0] alu_ctrl;
  logic [BITS-1:0]      alu_x;
  logic [BITS-1:0]      alu_y;
  logic [2*BITS-1:0]    alu_result;

  modport slave (
    input  r0_valid, r0_op, r0_x, r0_y,
    input  r1_valid, r1_op, r1_x, r1_y,
    output r0_ready, r1_ready,
    output rsp_valid, rsp_id, rsp_err, rsp_data,
    input  rsp_ready,
    output alu_ctrl, alu_x, alu_y,
    input  alu_result
  );

  modport master (
    output r0_valid, r0_op, r0_x, r0_y,
    output r1_valid, r1_op, r1_x, r1_y,
    input  r0_ready, r1_ready,
    input  rsp_valid, rsp_id, rsp_err, rsp_data,
    output rsp_ready,
    input  alu_ctrl, alu_x, alu_y,
    output alu_result
  );
endinterface

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU between two requesters. Requests are granted
// round-robin, operands are latched and presented to the ALU together with a
// one-hot control word for a fixed per-op latency (MULDIV_LAT for mul/div,
// 1 otherwise), and the registered 2*BITS result is returned with the
// requester id and an error flag. Only one operation is in flight at a time.
//
// Ports:
//   clk    - rising-edge clock
//   clr_n  - asynchronous active-low reset
//   bus    - alu_arbiter_if.slave (requests, response, ALU drive/return)
//
// Optional feature macro: ALU_ARB_DIV0_EN
//   When defined, a divide (op 3) with y == 0 is rejected at accept time with
//   rsp_err = 1 and never reaches the ALU. When undefined it executes normally.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int BITS       = 32,
  parameter int SIG_COUNT  = 12,
  parameter int MULDIV_LAT = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  alu_arbiter_if.slave  bus
);

  localparam int CNT_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;

  logic [1:0]        state;
  logic              ptr;        // requester favoured when both are valid
  logic [CNT_W-1:0]  cnt;
  logic [3:0]        op_q;
  logic [BITS-1:0]   x_q;
  logic [BITS-1:0]   y_q;
  logic              rsp_id_q;
  logic              rsp_err_q;
  logic [2*BITS-1:0] rsp_data_q;

  logic              grant_id;
  logic              accept;
  logic [3:0]        sel_op;
  logic [BITS-1:0]   sel_x;
  logic [BITS-1:0]   sel_y;
  logic              op_legal;
  logic              op_muldiv;
  logic              div_zero;

  // Grant: a lone valid wins outright; a tie goes to the pointer.
  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant_id = 1'b0;
    if (bus.r0_valid && bus.r1_valid) grant_id = ptr;
    else                              grant_id = bus.r1_valid;
  end

  assign accept       = (state == ST_IDLE) && (bus.r0_valid || bus.r1_valid);
  assign bus.r0_ready = accept && !grant_id;
  assign bus.r1_ready = accept &&  grant_id;

  assign sel_op = grant_id ? bus.r1_op : bus.r0_op;
  assign sel_x  = grant_id ? bus.r1_x  : bus.r0_x;
  assign sel_y  = grant_id ? bus.r1_y  : bus.r0_y;

  assign op_legal  = (int'(sel_op) < SIG_COUNT);
  assign op_muldiv = (sel_op == OP_MUL) || (sel_op == OP_DIV);

`ifdef ALU_ARB_DIV0_EN
  assign div_zero = (sel_op == OP_DIV) && (sel_y == '0);
`else
  assign div_zero = 1'b0;
`endif

  // The ALU only sees a control bit while an operation is executing; the
  // operands stay parked on the last latched values in between.
  assign bus.alu_ctrl = (state == ST_EXEC) ? (SIG_COUNT'(1) << op_q) : '0;
  assign bus.alu_x    = x_q;
  assign bus.alu_y    = y_q;

  assign bus.rsp_valid = (state == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (including the wide operand/result holders) is reset so the
  // outputs come out of reset at known values.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      cnt        <= '0;
      op_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rsp_id_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q     <= sel_op;
            x_q      <= sel_x;
            y_q      <= sel_y;
            rsp_id_q <= grant_id;
            ptr      <= ~grant_id;
            if (!op_legal || div_zero) begin
              // Rejected ops skip the ALU and answer on the next cycle.
              rsp_err_q  <= 1'b1;
              rsp_data_q <= '0;
              cnt        <= '0;
              state      <= ST_RESP;
            end else begin
              cnt   <= op_muldiv ? CNT_W'(MULDIV_LAT - 1) : '0;
              state <= ST_EXEC;
            end
          end
        end

        ST_EXEC: begin
          if (cnt == '0) begin
            rsp_data_q <= bus.alu_result;
            rsp_err_q  <= 1'b0;
            state      <= ST_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        ST_RESP: begin
          if (bus.rsp_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Directed self-checking bench for alu_arbiter. A behavioural model of the
// shared ALU answers alu_ctrl/alu_x/alu_y; every expected response value is a
// hand-computed constant. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  localparam int BITS = 32;
  localparam int SIG  = 12;
  localparam int LAT  = 4;

  logic clk = 1'b0;
  logic clr_n;

  always #5 clk = ~clk;

  alu_arbiter_if #(.BITS(BITS), .SIG_COUNT(SIG)) bus ();

  alu_arbiter #(
    .BITS       (BITS),
    .SIG_COUNT  (SIG),
    .MULDIV_LAT (LAT)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  // Behavioural shared ALU. Divide by zero returns all ones.
  always_comb begin
    bus.alu_result = '0;
    case (bus.alu_ctrl)
      12'h001: bus.alu_result = {32'h0, bus.alu_x + bus.alu_y};
      12'h002: bus.alu_result = {32'h0, bus.alu_x - bus.alu_y};
      12'h004: bus.alu_result = {32'h0, bus.alu_x} * {32'h0, bus.alu_y};
      12'h008: bus.alu_result = (bus.alu_y == 0) ? '1 :
                                {bus.alu_x % bus.alu_y, bus.alu_x / bus.alu_y};
      12'h010: bus.alu_result = {32'h0, bus.alu_x >> bus.alu_y[4:0]};
      12'h020: bus.alu_result = {32'h0, bus.alu_x << bus.alu_y[4:0]};
      12'h100: bus.alu_result = {32'h0, bus.alu_x & bus.alu_y};
      12'h200: bus.alu_result = {32'h0, bus.alu_x | bus.alu_y};
      12'h400: bus.alu_result = {32'h0, -bus.alu_x};
      12'h800: bus.alu_result = {32'h0, ~bus.alu_x};
      default: bus.alu_result = '0;
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit id, input logic [3:0] op, input logic [31:0] x,
                           input logic [31:0] y);
    if (id) begin
      bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_x = x; bus.r1_y = y;
    end else begin
      bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_x = x; bus.r0_y = y;
    end
  endtask

  task automatic drop_req(input bit id);
    if (id) bus.r1_valid = 1'b0;
    else    bus.r0_valid = 1'b0;
  endtask

  // Presents a request and returns just after the edge that accepted it.
  task automatic accept_req(input bit id, input logic [3:0] op, input logic [31:0] x,
                            input logic [31:0] y, input string tag);
    int n;
    @(negedge clk);
    drive_req(id, op, x, y);
    #1;
    n = 0;
    while (!(id ? bus.r1_ready : bus.r0_ready) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, "_accept_timeout"}, 64'(n < 20), 64'd1);
    @(posedge clk);
    #1;
    drop_req(id);
  endtask

  // Counts falling edges from accept until rsp_valid, tracking alu_ctrl.
  task automatic wait_rsp(output int lat, output int ctrl_cyc, output logic [11:0] ctrl_val);
    lat = 0; ctrl_cyc = 0; ctrl_val = '0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.alu_ctrl != '0) begin
        ctrl_cyc++;
        ctrl_val = bus.alu_ctrl;
      end
    end while (!bus.rsp_valid && lat < 40);
  endtask

  task automatic run_op(input bit id, input logic [3:0] op, input logic [31:0] x,
                        input logic [31:0] y, input int exp_lat, input logic [11:0] exp_ctrl,
                        input int exp_cyc, input logic [63:0] exp_data, input bit exp_err,
                        input string tag);
    int lat, cyc;
    logic [11:0] cv;
    accept_req(id, op, x, y, tag);
    wait_rsp(lat, cyc, cv);
    check({tag, "_latency"},   64'(lat), 64'(exp_lat));
    check({tag, "_ctrl"},      64'(cv),  64'(exp_ctrl));
    check({tag, "_ctrl_cyc"},  64'(cyc), 64'(exp_cyc));
    check({tag, "_data"},      bus.rsp_data, exp_data);
    check({tag, "_id"},        64'(bus.rsp_id),  64'(id));
    check({tag, "_err"},       64'(bus.rsp_err), 64'(exp_err));
    @(negedge clk);
    check({tag, "_idle_after"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
  endtask

  initial begin
    int lat, cyc, grants, n, seen;
    logic [11:0] cv;
    logic [63:0] snap;

    clr_n = 1'b0;
    bus.r0_valid = 1'b0; bus.r0_op = '0; bus.r0_x = '0; bus.r0_y = '0;
    bus.r1_valid = 1'b0; bus.r1_op = '0; bus.r1_x = '0; bus.r1_y = '0;
    bus.rsp_ready = 1'b0;
    #2;

    // Reset values and IDLE ready rule while held in reset.
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    check("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
    check("rst_rsp_data",  bus.rsp_data,       64'd0);
    check("rst_alu_ctrl",  64'(bus.alu_ctrl),  64'd0);
    check("rst_alu_xy",    {bus.alu_x, bus.alu_y}, 64'd0);
    check("rst_no_ready",  64'({bus.r0_ready, bus.r1_ready}), 64'd0);
    bus.r1_valid = 1'b1;
    #1;
    check("rst_r1_ready",  64'({bus.r0_ready, bus.r1_ready}), 64'b01);
    bus.r1_valid = 1'b0;
    @(negedge clk);
    clr_n = 1'b1;
    bus.rsp_ready = 1'b1;

    // Fast op, multiply, illegal op, then recovery with a subtract.
    run_op(1'b0, 4'd0,  32'd5,  32'd7, 2, 12'h001, 1,   64'd12, 1'b0, "add");
    run_op(1'b1, 4'd2,  32'd6,  32'd7, 5, 12'h004, LAT, 64'd42, 1'b0, "mul");
    run_op(1'b0, 4'd13, 32'd1,  32'd2, 1, 12'h000, 0,   64'd0,  1'b1, "illegal");
    run_op(1'b0, 4'd1,  32'd10, 32'd3, 2, 12'h002, 1,   64'd7,  1'b0, "sub");

    // Divide by zero, then a normal divide.
`ifdef ALU_ARB_DIV0_EN
    run_op(1'b0, 4'd3, 32'd9, 32'd0, 1, 12'h000, 0, 64'd0, 1'b1, "div0");
`else
    run_op(1'b0, 4'd3, 32'd9, 32'd0, 5, 12'h008, LAT, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, "div0");
`endif
    run_op(1'b0, 4'd3, 32'd9, 32'd3, 5, 12'h008, LAT, 64'd3, 1'b0, "div");
    check("alu_xy_hold", {bus.alu_x, bus.alu_y}, {32'd9, 32'd3});

    // Response back-pressure: outputs stable, no grant while stalled.
    bus.rsp_ready = 1'b0;
    accept_req(1'b0, 4'd0, 32'd100, 32'd23, "stall");
    wait_rsp(lat, cyc, cv);
    check("stall_data", bus.rsp_data, 64'd123);
    drive_req(1'b1, 4'd9, 32'hF0, 32'h0F);
    repeat (10) begin
      @(negedge clk);
      check("stall_hold", {bus.rsp_data[60:0], bus.rsp_valid, bus.rsp_id, bus.rsp_err},
            {61'd123, 1'b1, 1'b0, 1'b0});
      check("stall_no_ready", 64'({bus.r0_ready, bus.r1_ready}), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_idle", 64'({bus.rsp_valid, bus.r1_ready}), 64'b01);
    @(posedge clk);
    #1;
    drop_req(1'b1);
    wait_rsp(lat, cyc, cv);
    check("or_latency", 64'(lat), 64'd2);
    check("or_data",    bus.rsp_data, 64'hFF);
    check("or_id",      64'(bus.rsp_id), 64'd1);
    @(negedge clk);

    // Round robin with both requesters continuously valid, from reset.
    do_reset();
    drive_req(1'b0, 4'd0, 32'd1,  32'd2);
    drive_req(1'b1, 4'd1, 32'd10, 32'd4);
    grants = 0; seen = 0; n = 0;
    while (grants < 8 && n < 200) begin
      #1;
      if (bus.rsp_valid) begin
        check("rr_data", bus.rsp_data, bus.rsp_id ? 64'd6 : 64'd3);
        seen++;
      end
      if (bus.r0_ready || bus.r1_ready) begin
        check("rr_onehot", 64'(bus.r0_ready && bus.r1_ready), 64'd0);
        check("rr_grant",  64'(bus.r1_ready), 64'(grants % 2));
        grants++;
      end
      if (grants < 8) begin
        @(negedge clk);
        n++;
      end
    end
    check("rr_grant_count", 64'(grants), 64'd8);
    @(posedge clk);
    #1;
    drop_req(1'b0);
    drop_req(1'b1);
    wait_rsp(lat, cyc, cv);
    check("rr_last_data", bus.rsp_data, 64'd6);
    check("rr_resp_count", 64'(seen), 64'd7);
    @(negedge clk);

    // Reset in the middle of a multiply discards it.
    accept_req(1'b1, 4'd2, 32'd6, 32'd7, "rst_exec");
    @(negedge clk);
    check("rst_exec_ctrl_on", 64'(bus.alu_ctrl), 64'h004);
    clr_n = 1'b0;
    #1;
    check("rst_exec_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_exec_ctrl",  64'(bus.alu_ctrl),  64'd0);
    check("rst_exec_xy",    {bus.alu_x, bus.alu_y}, 64'd0);
    check("rst_exec_rsp",   {bus.rsp_data[61:0], bus.rsp_id, bus.rsp_err}, 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    snap = '0;
    repeat (8) begin
      @(negedge clk);
      if (bus.rsp_valid) snap++;
    end
    check("rst_exec_no_rsp", snap, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
